// File: rtl/out_port_arbiter.sv
//==============================================================================
// Module      : out_port_arbiter
// Description : Per-egress-port scheduler for the 4-port switch. Watches the
//               head header of each of the four ingress FIFOs, picks one
//               round-robin among the non-empty FIFOs whose head packet is
//               addressed to this port, pops it with a single-cycle read
//               pulse and presents the popped word on a valid/ready egress
//               interface.
//
// Ports       : clk          - system clock, rising edge
//               rst          - asynchronous active-high reset
//               fifo_empty   - per-FIFO empty flag (bit i = FIFO i)
//               fifo_header  - per-FIFO head header, slice i = [i*HDR_WIDTH +: HDR_WIDTH]
//               fifo_data    - per-FIFO registered read data, slice i
//               rd_en        - one-hot read pulse to FIFO i
//               out_data     - egress packet word
//               out_valid    - out_data valid
//               out_ready    - downstream accept
//               out_src      - ingress index of the packet on out_data
//               busy         - FSM not in IDLE
//               pkt_count    - accepted packet counter (ARB_PKT_CNT_EN only)
//
// Options     : `define ARB_PKT_CNT_EN adds the 16-bit saturating pkt_count
//               output. Without it the port and the counter are absent.
//
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package packet_pkg;
    localparam int DATA_WIDTH = 16;
endpackage

module out_port_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_ID    = 0,
    parameter int DATA_WIDTH = packet_pkg::DATA_WIDTH,
    parameter int HDR_WIDTH  = DATA_WIDTH / 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            fifo_empty,
    input  logic [NUM_PORTS*HDR_WIDTH-1:0]  fifo_header,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_data,
    output logic [NUM_PORTS-1:0]            rd_en,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [1:0]                      out_src,
    output logic                            busy
`ifdef ARB_PKT_CNT_EN
    ,
    output logic [15:0]                     pkt_count
`endif
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    // Destination field of a header is its two LSBs.
    localparam logic [1:0] c_PORT_DEST = PORT_ID[1:0];

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_SEND  = 2'd2;

    //--------------------------------------------------------------------------
    // Declarations
    //--------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [1:0]            r_rr_ptr;
    logic [1:0]            r_gnt;

    logic [NUM_PORTS-1:0]  w_elig;
    logic [DATA_WIDTH-1:0] w_data_arr [NUM_PORTS];
    logic                  w_found;
    logic [1:0]            w_gnt_idx;
    logic [1:0]            w_cand;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // Only the destination bits of each header are inspected; the remaining
    // header bits are deliberately left unconsumed.
    logic                  w_unused_hdr;
    assign w_unused_hdr = ^fifo_header;

    //--------------------------------------------------------------------------
    // Per-FIFO eligibility and data unpacking. An empty FIFO's header is
    // don't-care, so the empty flag masks the destination compare.
    //--------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_fifo
        assign w_elig[gi]     = !fifo_empty[gi] &&
                                (fifo_header[gi*HDR_WIDTH +: 2] == c_PORT_DEST);
        assign w_data_arr[gi] = fifo_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    //--------------------------------------------------------------------------
    // Round-robin search: start at r_rr_ptr and walk upward, wrapping 3->0.
    // The 2-bit candidate index wraps naturally.
    //--------------------------------------------------------------------------
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = r_rr_ptr;
        w_cand    = r_rr_ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_cand = r_rr_ptr + 2'(k);
            if (!w_found && w_elig[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Read pulse: combinational, only in IDLE, at most one bit. It is also
    // masked by rst so that the FIFOs are never popped while the arbiter is
    // held in reset (the FSM sits in IDLE during reset and would otherwise
    // expose a request).
    //--------------------------------------------------------------------------
    always_comb begin
        rd_en = '0;
        if (!rst && (r_state == c_IDLE) && w_found) begin
            rd_en[w_gnt_idx] = 1'b1;
        end
    end

    assign w_sel_data = w_data_arr[r_gnt];
    assign busy       = (r_state != c_IDLE);

    //--------------------------------------------------------------------------
    // Control FSM and egress register.
    //   IDLE  : grant recorded, pointer advanced past the winner.
    //   FETCH : FIFO read data is valid this cycle (registered read), capture.
    //   SEND  : hold the word until accepted; no new grant meanwhile, so
    //           backpressure simply leaves packets waiting in the FIFOs.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_rr_ptr  <= 2'd0;
            r_gnt     <= 2'd0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_src   <= 2'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_gnt    <= w_gnt_idx;
                        r_rr_ptr <= w_gnt_idx + 2'd1;
                        r_state  <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    out_data  <= w_sel_data;
                    out_src   <= r_gnt;
                    out_valid <= 1'b1;
                    r_state   <= c_SEND;
                end
                c_SEND: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= c_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    r_state   <= c_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PKT_CNT_EN
    //--------------------------------------------------------------------------
    // Accepted-packet counter, saturating at all-ones.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count <= 16'd0;
        end else if (out_valid && out_ready && (pkt_count != 16'hFFFF)) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_out_port_arbiter.sv
//==============================================================================
// Module      : tb_out_port_arbiter
// Description : Self-checking bench for out_port_arbiter (PORT_ID = 0).
//               Directed stimulus loads a behavioural FIFO model; expected
//               grants and egress words are queued by the stimulus and
//               popped by an independent monitor.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_out_port_arbiter;

    localparam int DW = 16;
    localparam int HW = 8;
    localparam int NP = 4;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic [NP-1:0]     fifo_empty;
    logic [NP*HW-1:0]  fifo_header;
    logic [NP*DW-1:0]  fifo_data = '0;
    logic [NP-1:0]     rd_en;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [1:0]        out_src;
    logic              busy;
`ifdef ARB_PKT_CNT_EN
    logic [15:0]       pkt_count;
`endif

    // Behavioural FIFOs: written by stimulus, popped by rd_en.
    logic [DW-1:0]     mem  [NP][256];
    logic [7:0]        wptr [NP];
    logic [7:0]        rptr [NP] = '{default: 8'd0};

    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc   = 0;
    int                lat   = 0;
    int                prev_gnt_cyc = 0;
    int                n_acc = 0;
    bit                have_prev = 1'b0;
    bit                gap_chk   = 1'b0;
    int                exp_gnt [$];
    logic [17:0]       exp_out [$];   // {src, data}
    int                g;
    logic [17:0]       e;

    always #5 clk = ~clk;

    out_port_arbiter #(
        .NUM_PORTS  (NP),
        .PORT_ID    (0),
        .DATA_WIDTH (DW),
        .HDR_WIDTH  (HW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_header (fifo_header),
        .fifo_data   (fifo_data),
        .rd_en       (rd_en),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_src     (out_src),
        .busy        (busy)
`ifdef ARB_PKT_CNT_EN
        ,
        .pkt_count   (pkt_count)
`endif
    );

    for (genvar gi = 0; gi < NP; gi++) begin : g_fifo
        assign fifo_empty[gi]            = (rptr[gi] == wptr[gi]);
        assign fifo_header[gi*HW +: HW]  = mem[gi][rptr[gi]][HW-1:0];
    end

    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (rd_en[i]) begin
                fifo_data[i*DW +: DW] <= mem[i][rptr[i]];
                rptr[i]               <= rptr[i] + 8'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got 0x%0h expected nothing at %0t", name, act, $time);
    endtask

    task automatic push_pkt(input int i, input logic [DW-1:0] w);
        mem[i][wptr[i]] = w;
        wptr[i]         = wptr[i] + 8'd1;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_gnt.size() != 0 || exp_out.size() != 0 || busy) && k < budget) begin
            @(posedge clk); #3;
            k++;
        end
        chk("drain_done", {29'd0, exp_gnt.size() != 0, exp_out.size() != 0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
    endtask

    // Monitor: grants, latency, spacing and egress words.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            lat   = 0;
            n_acc = 0;
        end else begin
            if (lat > 0) begin
                lat = lat - 1;
                chk("latency_valid", {31'd0, out_valid}, (lat == 0) ? 32'd1 : 32'd0);
            end
            if (rd_en != '0) begin
                if (exp_gnt.size() == 0) begin
                    fail_now("unexpected_grant", {28'd0, rd_en});
                end else begin
                    g = exp_gnt.pop_front();
                    chk("grant", {28'd0, rd_en}, 32'd1 << g);
                end
                if (gap_chk && have_prev)
                    chk("grant_gap", cyc - prev_gnt_cyc, 32'd3);
                prev_gnt_cyc = cyc;
                have_prev    = 1'b1;
                lat          = 2;
            end
            if (out_valid && out_ready) begin
                n_acc = n_acc + 1;
                if (exp_out.size() == 0) begin
                    fail_now("unexpected_output", {14'd0, out_src, out_data});
                end else begin
                    e = exp_out.pop_front();
                    chk("out_data", {16'd0, out_data}, {16'd0, e[15:0]});
                    chk("out_src", {30'd0, out_src}, {30'd0, e[17:16]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NP; i++) begin
            wptr[i] = 8'd0;
            for (int j = 0; j < 256; j++) mem[i][j] = '0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        #3;
        chk("rst_rd_en", {28'd0, rd_en}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_src", {30'd0, out_src}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #2 rst = 1'b0;

        // T1: single packet from FIFO1
        exp_gnt.push_back(1);
        exp_out.push_back({2'd1, 16'h1100});
        push_pkt(1, 16'h1100);
        #1 chk("t1_rd_en", {28'd0, rd_en}, 32'h2);
        @(posedge clk); #3;
        chk("t1_rd_en_pulse", {28'd0, rd_en}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_drain(50);

        // T2: all four eligible, fresh pointer -> 0,1,2,3,0 at 3-cycle spacing
        do_reset();
        have_prev = 1'b0;
        gap_chk   = 1'b1;
        exp_gnt.push_back(0); exp_out.push_back({2'd0, 16'h3000});
        exp_gnt.push_back(1); exp_out.push_back({2'd1, 16'h3100});
        exp_gnt.push_back(2); exp_out.push_back({2'd2, 16'h3200});
        exp_gnt.push_back(3); exp_out.push_back({2'd3, 16'h3300});
        exp_gnt.push_back(0); exp_out.push_back({2'd0, 16'h3400});
        push_pkt(0, 16'h3000);
        push_pkt(0, 16'h3400);
        push_pkt(1, 16'h3100);
        push_pkt(2, 16'h3200);
        push_pkt(3, 16'h3300);
        wait_drain(100);
        gap_chk = 1'b0;

        // T3: FIFO1 head addressed to port 1 -> never read, stays blocked
        @(posedge clk); #2 push_pkt(1, 16'h4101);
        repeat (4) begin
            repeat (5) @(posedge clk);
            #3;
            chk("t3_busy", {31'd0, busy}, 32'd0);
            chk("t3_rd_en", {28'd0, rd_en}, 32'd0);
        end

        // T4: backpressure holds the word; FIFO3 waits until accept
        @(posedge clk); #2;
        out_ready = 1'b0;
        exp_gnt.push_back(0);
        exp_out.push_back({2'd0, 16'h5000});
        push_pkt(0, 16'h5000);
        for (int k = 0; k < 10 && !out_valid; k++) begin
            @(posedge clk); #3;
        end
        chk("t4_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #2 push_pkt(3, 16'h5300);
        repeat (10) begin
            @(posedge clk); #3;
            chk("t4_hold_data", {16'd0, out_data}, 32'h5000);
            chk("t4_hold_src", {30'd0, out_src}, 32'd0);
            chk("t4_hold_rd_en", {28'd0, rd_en}, 32'd0);
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        exp_gnt.push_back(3);
        exp_out.push_back({2'd3, 16'h5300});
        @(posedge clk); #3;
        chk("t4_next_grant", {28'd0, rd_en}, 32'h8);
        wait_drain(50);

        // T5: reset during FETCH; popped packet lost, pointer back to 0
        @(posedge clk); #2;
        exp_gnt.push_back(2);
        push_pkt(2, 16'h6200);
        push_pkt(2, 16'h6204);
        #1 chk("t5_grant2", {28'd0, rd_en}, 32'h4);
        @(posedge clk); #2;
        chk("t5_in_fetch", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_rd_en", {28'd0, rd_en}, 32'd0);
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_data", {16'd0, out_data}, 32'd0);
        chk("t5_rst_src", {30'd0, out_src}, 32'd0);
        push_pkt(0, 16'h6000);
        exp_gnt.push_back(0); exp_out.push_back({2'd0, 16'h6000});
        exp_gnt.push_back(2); exp_out.push_back({2'd2, 16'h6204});
        @(posedge clk); #3;
        chk("t5_rd_en_in_reset", {28'd0, rd_en}, 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        #1 chk("t5_fifo0_wins", {28'd0, rd_en}, 32'h1);
        wait_drain(50);

`ifdef ARB_PKT_CNT_EN
        chk("pkt_count", {16'd0, pkt_count}, n_acc);
`endif
        chk("end_exp_gnt_empty", exp_gnt.size(), 32'd0);
        chk("end_exp_out_empty", exp_out.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
